// File: rtl/spatial_processing_unit_seq_if.sv
// Operand/result handshake bundle for spatial_processing_unit_seq.
interface spatial_processing_unit_seq_if #(
  parameter int W  = 8,
  parameter int RW = 2 * W
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic [W-1:0]  d;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          busy;

  modport master (
    output in_valid, op, a, b, c, d, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, c, d, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/spatial_processing_unit_seq.sv
// Spatial ALU: mean, Manhattan distance, box area (sequential multiply), lane multiply.
// Optional macro SPU_ROUND_EN makes the focal mean round half up instead of truncating.
module spatial_processing_unit_seq #(
  parameter int W  = 8,
  parameter int RW = 2 * W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  spatial_processing_unit_seq_if.slave bus
);
  localparam int H  = W / 2;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] mcand_q;
  logic [W-1:0]  mplier_q;
  logic [RW-1:0] acc_q;
  logic [RW-1:0] acc_d;
  logic [RW-1:0] result_q;
  logic          out_valid_q;

  logic [W+1:0]  sum;
  logic [W-1:0]  mean;
  logic [W-1:0]  dac;
  logic [W-1:0]  dbd;
  logic [W:0]    manh;
  logic [W-1:0]  lane_lo;
  logic [W-1:0]  lane_hi;
  logic [RW-1:0] fast_res;

  always_comb begin
    sum = {2'b00, bus.a} + {2'b00, bus.b} + {2'b00, bus.c} + {2'b00, bus.d};
`ifdef SPU_ROUND_EN
    sum = sum + (W+2)'(2);
`else
    sum = sum + '0;
`endif
    mean    = sum[W+1:2];
    dac     = (bus.a >= bus.c) ? (bus.a - bus.c) : (bus.c - bus.a);
    dbd     = (bus.b >= bus.d) ? (bus.b - bus.d) : (bus.d - bus.b);
    manh    = {1'b0, dac} + {1'b0, dbd};
    lane_lo = W'(bus.a[H-1:0]) * W'(bus.b[H-1:0]);
    lane_hi = W'(bus.c[H-1:0]) * W'(bus.d[H-1:0]);
    fast_res = '0;
    case (bus.op)
      2'b00:   fast_res = RW'(mean);
      2'b01:   fast_res = RW'(manh);
      2'b11:   fast_res = {lane_hi, lane_lo};
      default: fast_res = '0;
    endcase
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // All state sits under ena so a deasserted enable freezes the FSM, counter and product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == 2'b10) begin
              state_q  <= MUL;
              mcand_q  <= RW'(dac);
              mplier_q <= dbd;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else begin
              state_q     <= DONE;
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_q     <= DONE;
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ena;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/spatial_processing_unit_seq.md
SPATIAL_PROCESSING_UNIT_SEQ -- requirements
Module: spatial_processing_unit_seq

Interface
REQ-001 Parameter W, default 8, operand width; the SHALL constraint is even and >= 4.
REQ-002 Parameter RW, default 2*W, result width; the SHALL constraint is that it is fixed at 2*W and never overridden.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  clock enable; 0 freezes all state.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 op  input  2  00 focal mean, 01 Manhattan distance, 10 box area, 11 lane tensor multiply.
REQ-009 a, b, c, d  input  W each  unsigned operands.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  RW  unsigned result, zero-extended.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, MUL and DONE.
REQ-015 in_ready SHALL be combinational: (state==IDLE) & ena.
REQ-016 A beat SHALL be accepted on a rising edge with in_valid & in_ready; op and operands are captured, and other inputs are ignored.
REQ-017 For op 00, 01 and 11, accept SHALL go IDLE->DONE, with out_valid high on the cycle after acceptance (latency 1).
REQ-018 Op 00 SHALL compute (a+b+c+d)>>2 with a W+2-bit sum, giving a W-bit result.
REQ-019 Op 01 SHALL compute |a-c|+|b-d| in W+1 bits.
REQ-020 Op 10 SHALL compute |c-a|*|d-b| in 2W bits using a sequential shift-add multiplier, one multiplier bit per enabled cycle.
REQ-021 Op 10 accept SHALL go IDLE->MUL; MUL lasts exactly W enabled cycles, then goes to DONE; out_valid rises W+1 enabled cycles after acceptance.
REQ-022 Op 11 SHALL compute with H=W/2: result = {c[H-1:0]*d[H-1:0], a[H-1:0]*b[H-1:0]}, each lane W bits.
REQ-023 In DONE, result and out_valid SHALL hold stable until out_ready is high on an enabled edge, then go to IDLE; out_valid drops on the same edge.
REQ-024 No new beat SHALL be accepted in MUL or DONE (no overlap), so a back-to-back throughput of one result per 2 cycles is the maximum.
REQ-025 With ena=0, the state, multiplier counter, partial product and outputs SHALL hold; in_ready is 0; out_ready is ignored.
REQ-026 result SHALL be 0 whenever out_valid is 0.
REQ-027 Zero operands (e.g. c==a in op 10) SHALL still take the full W MUL cycles and yield 0.

Reset
REQ-028 While rst_n is low: state IDLE, out_valid=0, result=0, busy=0, multiplier counter and partial product 0; in_ready follows ena; in_valid is ignored.
REQ-029 Reset asserted in MUL or DONE SHALL abort the operation; the pending result is discarded and never presented after release.
REQ-030 The first beat SHALL be acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro SPU_ROUND_EN: when defined, op 00 SHALL compute (a+b+c+d+2)>>2, rounding half up, with a W+2-bit sum and no overflow.
REQ-032 Without SPU_ROUND_EN, op 00 SHALL truncate per REQ-018; all other ops are unaffected in either case.

Verification (W=8, ena=1 unless stated)
REQ-033 Mean: op00 with a=4, b=8, c=6, d=2 gives result=5 one cycle after accept; with a=3, b=4, c=4, d=4 it gives 3, or 4 under SPU_ROUND_EN.
REQ-034 Manhattan: op01 with a=5, b=3, c=1, d=7 gives 8; with a=200, b=0, c=10, d=255 it gives 0x1BD.
REQ-035 Box area: op10 with a=2, b=3, c=5, d=1 gives 6, with out_valid exactly 9 cycles after accept and busy high throughout; with a=0, b=0, c=255, d=255 it gives 65025.
REQ-036 Tensor: op11 with a=0x32, b=0x0F, c=0x04, d=0x05 gives 0x141E.
REQ-037 Backpressure/stall: hold out_ready=0 for 5 cycles in DONE; then result stays stable and in_ready=0; pulse ena=0 for 3 cycles mid-MUL; then latency extends by 3 and the product is unchanged.
REQ-038 Reset mid-MUL: drop rst_n at cycle 4 of an op10; then out_valid=0 and result=0 immediately; after release, op01 returns its correct result with no stale output.
